avr_decode_stage: RTL and testbench
===================================

# avr_decode_stage

Registered, handshaked instruction-decode stage for the AVR-subset core. It sits between the fetch unit and the register-file/ALU stage and accepts one 16-bit program word per cycle over a valid/ready interface. It decodes the supported opcode set into type, group and operand fields, and collects the second word of 32-bit instructions through a small state machine. It presents one decoded instruction per output handshake and is parametrised in instruction, register-address and immediate width.

## Interface

- `INSTR_WIDTH`, 16, program word width.
- `R_ADDR_WIDTH`, 5, register-file address width.
- `IMM_WIDTH`, 16, immediate/address field width; must be ≥ 8 and ≤ 2·`INSTR_WIDTH`.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — synchronous, active-high.
- `flush` input 1 — synchronous pipeline flush; discards any partial or pending instruction.
- `in_word` input `INSTR_WIDTH` — program word from fetch.
- `in_valid` input 1 — `in_word` is valid.
- `in_ready` output 1 — stage accepts `in_word` this cycle.
- `out_valid` output 1 — decoded instruction is valid.
- `out_ready` input 1 — downstream accepts the decoded instruction.
- `opcode_type` output `` `OPCODE_COUNT `` — one-hot type from `defines.vh`.
- `opcode_group` output `` `GROUP_COUNT `` — group flags from `defines.vh`.
- `opcode_rd` output `R_ADDR_WIDTH` — destination register.
- `opcode_rr` output `R_ADDR_WIDTH` — source register.
- `opcode_imm` output `IMM_WIDTH` — immediate or data address.

## Operation

- A word transfers when `in_valid && in_ready`. The decoded result transfers when `out_valid && out_ready`.
- States:
  - `S_WORD1` — awaiting the first word of an instruction.
  - `S_WORD2` — first word of a two-word instruction held; awaiting the second.
- Transitions:
  - `S_WORD1` → `S_WORD2` on accepting LDS or STS.
  - `S_WORD2` → `S_WORD1` on accepting any word.
  - All other accepts stay in `S_WORD1`.
- `in_ready = !out_valid || out_ready` in both states, giving full throughput with no bubble.
- Decoding; unused fields drive 0, never x:
  - NOP `0000_0000_0000_0000`: rd = rr = imm = 0.
  - ADD `0000_11rd_dddd_rrrr`, ADC `0001_11..`, SUB `0001_10..`, AND `0010_00..`, OR `0010_10..`, MOV `0010_11..`: rd = `[8:4]`, rr = `{[9],[3:0]}`.
  - NEG `1001_010d_dddd_0001`: rd = `[8:4]`.
  - LDI `1110_KKKK_dddd_KKKK`: rd = `{1'b1,[7:4]}`; imm = `{[11:8],[3:0]}`, zero-extended to `IMM_WIDTH`.
  - LDS `1001_000d_dddd_0000` + k: rd = `[8:4]`, imm = second word.
  - STS `1001_001r_rrrr_0000` + k: rr = `[8:4]`, imm = second word.
  - The second word is truncated or zero-extended to `IMM_WIDTH`.
  - Any other pattern → `TYPE_UNKNOWN`, single word.
- Groups:
  - `GROUP_ALU_ONE_OP` = NEG.
  - `GROUP_ALU_TWO_OP` = ADD/ADC/SUB/AND/OR.
  - `GROUP_ALU` = OR of the two above.
  - `GROUP_TWO_WORD` = LDS/STS.
  - MOV, LDI and NOP set no ALU group.
- In `S_WORD2`, the accepted word is treated as data regardless of its bit pattern.
- `flush`: clears `out_valid` and returns to `S_WORD1` in the same edge; `in_ready` is forced to 0 during the flush cycle. `reset` has priority over `flush`.

## Timing

- Reset values: `out_valid` = 0, `opcode_type` = `TYPE_NOP`, `opcode_group` = 0, rd = rr = imm = 0, state `S_WORD1`.
- One-word instruction accepted at edge N → `out_valid` = 1 after edge N.
- Two-word instruction: first word at edge N, second at edge M > N → `out_valid` after edge M. No output is produced for the first word.
- Output holds stable while `out_valid && !out_ready`.
- A simultaneous output consume and input accept in the same cycle replaces the output register; there is no gap.
- `in_valid` low while in `S_WORD2`: the state is held indefinitely.
- Reset or flush while in `S_WORD2` discards the held first word.

## Configuration

- `DECODE_TWO_WORD_EN` defined:
  - LDS/STS are decoded as described above.
  - `S_WORD2` exists.
  - `GROUP_TWO_WORD` is driven.
- Not defined:
  - LDS/STS patterns decode as `TYPE_UNKNOWN`, single word.
  - The FSM is reduced to `S_WORD1` only.
  - `GROUP_TWO_WORD` is tied to 0.
  - Every accepted word yields one output.

## Test plan

- **Reset state.** Reset held 2 cycles → `out_valid` = 0, `opcode_type` = `TYPE_NOP`, all fields 0, `in_ready` = 1.
- **Back-to-back one-word stream.** Words `0x0C12` (ADD r1,r2), `0x9501` (NEG r16), `0xE5A3` (LDI r26,0x53) streamed with `out_ready` = 1:
  - Outputs arrive 1 cycle after each accept, with rd/rr/imm = 1/2/–, 16/0/–, 26/0/0x53.
  - Groups are TWO_OP, ONE_OP and none respectively.
- **Two-word instruction with gap.** `0x9100` (LDS r16), 3 idle cycles, then `0x0460`:
  - Exactly one output: LDS, rd = 16, imm = 0x0460, `GROUP_TWO_WORD` = 1.
  - With the macro off: `0x9100` → `TYPE_UNKNOWN` and `0x0460` → `TYPE_UNKNOWN`.
- **Backpressure.** `out_ready` = 0 for 4 cycles after ADD output → output fields stable, `in_ready` = 0. On release, the next queued word is accepted in the same cycle.
- **Flush mid-instruction.** Flush after `0x9300` (STS) first word, then `0x2C01` → single MOV r0,r1 output; the STS is never emitted.
- **Unknown encoding.** `0xFFFF` → `TYPE_UNKNOWN`, groups 0, fields 0.

Source files
------------

// File: rtl/avr_decode_stage.sv
// Registered valid/ready decode stage for the AVR-subset core.
// Define DECODE_TWO_WORD_EN to decode LDS/STS and enable the second-word state.
`ifndef OPCODE_COUNT
`define OPCODE_COUNT      12
`define TYPE_NOP          0
`define TYPE_ADD          1
`define TYPE_ADC          2
`define TYPE_SUB          3
`define TYPE_AND          4
`define TYPE_OR           5
`define TYPE_MOV          6
`define TYPE_NEG          7
`define TYPE_LDI          8
`define TYPE_LDS          9
`define TYPE_STS          10
`define TYPE_UNKNOWN      11
`define GROUP_COUNT       4
`define GROUP_ALU         0
`define GROUP_ALU_ONE_OP  1
`define GROUP_ALU_TWO_OP  2
`define GROUP_TWO_WORD    3
`endif

module avr_decode_stage #(
  parameter int INSTR_WIDTH  = 16,
  parameter int R_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [INSTR_WIDTH-1:0]    in_word,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`OPCODE_COUNT-1:0]  opcode_type,
  output logic [`GROUP_COUNT-1:0]   opcode_group,
  output logic [R_ADDR_WIDTH-1:0]   opcode_rd,
  output logic [R_ADDR_WIDTH-1:0]   opcode_rr,
  output logic [IMM_WIDTH-1:0]      opcode_imm
);

  typedef enum logic {S_WORD1, S_WORD2} state_t;

  state_t                     state_reg, state_next;
  logic                       out_valid_reg, out_valid_next;
  logic [`OPCODE_COUNT-1:0]   type_reg, type_next;
  logic [R_ADDR_WIDTH-1:0]    rd_reg, rd_next;
  logic [R_ADDR_WIDTH-1:0]    rr_reg, rr_next;
  logic [IMM_WIDTH-1:0]       imm_reg, imm_next;

  logic [15:0]                w;
  logic [`OPCODE_COUNT-1:0]   dec_type;
  logic [R_ADDR_WIDTH-1:0]    dec_rd, dec_rr;
  logic [IMM_WIDTH-1:0]       dec_imm;
  logic                       accept, consume;

`ifdef DECODE_TWO_WORD_EN
  logic                       dec_two_word;
  logic [`OPCODE_COUNT-1:0]   held_type_reg, held_type_next;
  logic [R_ADDR_WIDTH-1:0]    held_rd_reg, held_rd_next;
  logic [R_ADDR_WIDTH-1:0]    held_rr_reg, held_rr_next;
`endif

  assign w        = in_word[15:0];
  assign in_ready = (!out_valid_reg || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;

  always_comb begin
    dec_type = '0;
    dec_rd   = '0;
    dec_rr   = '0;
    dec_imm  = '0;
`ifdef DECODE_TWO_WORD_EN
    dec_two_word = 1'b0;
`endif
    casez (w)
      16'b0000_0000_0000_0000: dec_type[`TYPE_NOP] = 1'b1;
      16'b0000_11??_????_????,
      16'b0001_11??_????_????,
      16'b0001_10??_????_????,
      16'b0010_00??_????_????,
      16'b0010_10??_????_????,
      16'b0010_11??_????_????: begin
        dec_rd = R_ADDR_WIDTH'(w[8:4]);
        dec_rr = R_ADDR_WIDTH'({w[9], w[3:0]});
        case (w[13:10])
          4'b0011: dec_type[`TYPE_ADD] = 1'b1;
          4'b0111: dec_type[`TYPE_ADC] = 1'b1;
          4'b0110: dec_type[`TYPE_SUB] = 1'b1;
          4'b1000: dec_type[`TYPE_AND] = 1'b1;
          4'b1010: dec_type[`TYPE_OR]  = 1'b1;
          default: dec_type[`TYPE_MOV] = 1'b1;
        endcase
      end
      16'b1001_010?_????_0001: begin
        dec_type[`TYPE_NEG] = 1'b1;
        dec_rd = R_ADDR_WIDTH'(w[8:4]);
      end
      16'b1110_????_????_????: begin
        // LDI only reaches the upper half of the register file
        dec_type[`TYPE_LDI] = 1'b1;
        dec_rd  = R_ADDR_WIDTH'({1'b1, w[7:4]});
        dec_imm = IMM_WIDTH'({w[11:8], w[3:0]});
      end
`ifdef DECODE_TWO_WORD_EN
      16'b1001_000?_????_0000: begin
        dec_type[`TYPE_LDS] = 1'b1;
        dec_rd = R_ADDR_WIDTH'(w[8:4]);
        dec_two_word = 1'b1;
      end
      16'b1001_001?_????_0000: begin
        dec_type[`TYPE_STS] = 1'b1;
        dec_rr = R_ADDR_WIDTH'(w[8:4]);
        dec_two_word = 1'b1;
      end
`endif
      default: dec_type[`TYPE_UNKNOWN] = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_WORD1;
    end else if (accept) begin
`ifdef DECODE_TWO_WORD_EN
      if (state_reg == S_WORD1 && dec_two_word)
        state_next = S_WORD2;
      else
        state_next = S_WORD1;
`else
      state_next = S_WORD1;
`endif
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    type_next      = type_reg;
    rd_next        = rd_reg;
    rr_next        = rr_reg;
    imm_next       = imm_reg;
`ifdef DECODE_TWO_WORD_EN
    held_type_next = held_type_reg;
    held_rd_next   = held_rd_reg;
    held_rr_next   = held_rr_reg;
`endif
    if (flush) begin
      out_valid_next = 1'b0;
    end else begin
      if (consume)
        out_valid_next = 1'b0;
      if (accept) begin
`ifdef DECODE_TWO_WORD_EN
        // In S_WORD2 the word is the address, whatever it looks like
        if (state_reg == S_WORD2) begin
          out_valid_next = 1'b1;
          type_next      = held_type_reg;
          rd_next        = held_rd_reg;
          rr_next        = held_rr_reg;
          imm_next       = IMM_WIDTH'(in_word);
        end else if (dec_two_word) begin
          held_type_next = dec_type;
          held_rd_next   = dec_rd;
          held_rr_next   = dec_rr;
        end else
`endif
        begin
          out_valid_next = 1'b1;
          type_next      = dec_type;
          rd_next        = dec_rd;
          rr_next        = dec_rr;
          imm_next       = dec_imm;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_WORD1;
      out_valid_reg <= 1'b0;
      type_reg      <= `OPCODE_COUNT'(1) << `TYPE_NOP;
      rd_reg        <= '0;
      rr_reg        <= '0;
      imm_reg       <= '0;
`ifdef DECODE_TWO_WORD_EN
      held_type_reg <= '0;
      held_rd_reg   <= '0;
      held_rr_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      type_reg      <= type_next;
      rd_reg        <= rd_next;
      rr_reg        <= rr_next;
      imm_reg       <= imm_next;
`ifdef DECODE_TWO_WORD_EN
      held_type_reg <= held_type_next;
      held_rd_reg   <= held_rd_next;
      held_rr_reg   <= held_rr_next;
`endif
    end
  end

  always_comb begin
    opcode_group = '0;
    opcode_group[`GROUP_ALU_ONE_OP] = type_reg[`TYPE_NEG];
    opcode_group[`GROUP_ALU_TWO_OP] = type_reg[`TYPE_ADD] | type_reg[`TYPE_ADC] |
                                      type_reg[`TYPE_SUB] | type_reg[`TYPE_AND] |
                                      type_reg[`TYPE_OR];
    opcode_group[`GROUP_ALU] = opcode_group[`GROUP_ALU_ONE_OP] |
                               opcode_group[`GROUP_ALU_TWO_OP];
`ifdef DECODE_TWO_WORD_EN
    opcode_group[`GROUP_TWO_WORD] = type_reg[`TYPE_LDS] | type_reg[`TYPE_STS];
`endif
  end

  assign out_valid   = out_valid_reg;
  assign opcode_type = type_reg;
  assign opcode_rd   = rd_reg;
  assign opcode_rr   = rr_reg;
  assign opcode_imm  = imm_reg;

endmodule

// File: tb/tb_avr_decode_stage.sv
// Self-checking bench for avr_decode_stage: directed scenarios plus a randomized
// stream compared against a transaction-level decode model.
module tb_avr_decode_stage;

  localparam int OC = 12;
  localparam int GC = 4;
  localparam int K_NOP = 0, K_ADD = 1, K_ADC = 2, K_SUB = 3, K_AND = 4, K_OR = 5;
  localparam int K_MOV = 6, K_NEG = 7, K_LDI = 8, K_LDS = 9, K_STS = 10, K_UNK = 11;
`ifdef DECODE_TWO_WORD_EN
  localparam bit TWO_EN = 1'b1;
`else
  localparam bit TWO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [15:0]   in_word = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OC-1:0] opcode_type;
  logic [GC-1:0] opcode_group;
  logic [4:0]    opcode_rd, opcode_rr;
  logic [15:0]   opcode_imm;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [15:0] imm;
    bit          two;
  } dec_t;

  dec_t m_out, m_held;
  bit   m_valid = 1'b0;
  bit   m_pend  = 1'b0;

  avr_decode_stage #(.INSTR_WIDTH(16), .R_ADDR_WIDTH(5), .IMM_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_type(opcode_type), .opcode_group(opcode_group),
    .opcode_rd(opcode_rd), .opcode_rr(opcode_rr), .opcode_imm(opcode_imm)
  );

  always #5 clk = ~clk;

  function automatic dec_t model_dec(input logic [15:0] wd);
    dec_t d;
    d.kind = K_UNK; d.rd = 0; d.rr = 0; d.imm = 0; d.two = 0;
    if (wd == 16'h0000) d.kind = K_NOP;
    else if ((wd & 16'hFC00) == 16'h0C00) d.kind = K_ADD;
    else if ((wd & 16'hFC00) == 16'h1C00) d.kind = K_ADC;
    else if ((wd & 16'hFC00) == 16'h1800) d.kind = K_SUB;
    else if ((wd & 16'hFC00) == 16'h2000) d.kind = K_AND;
    else if ((wd & 16'hFC00) == 16'h2800) d.kind = K_OR;
    else if ((wd & 16'hFC00) == 16'h2C00) d.kind = K_MOV;
    else if ((wd & 16'hFE0F) == 16'h9401) d.kind = K_NEG;
    else if ((wd & 16'hF000) == 16'hE000) d.kind = K_LDI;
    else if (TWO_EN && (wd & 16'hFE0F) == 16'h9000) d.kind = K_LDS;
    else if (TWO_EN && (wd & 16'hFE0F) == 16'h9200) d.kind = K_STS;
    if (d.kind >= K_ADD && d.kind <= K_MOV) begin
      d.rd = 5'((wd >> 4) % 32);
      d.rr = 5'((wd % 16) + ((wd >> 9) % 2) * 16);
    end else if (d.kind == K_NEG || d.kind == K_LDS) begin
      d.rd = 5'((wd >> 4) % 32);
    end else if (d.kind == K_STS) begin
      d.rr = 5'((wd >> 4) % 32);
    end else if (d.kind == K_LDI) begin
      d.rd = 5'(16 + (wd >> 4) % 16);
      d.imm = 16'(((wd >> 8) % 16) * 16 + wd % 16);
    end
    d.two = (d.kind == K_LDS || d.kind == K_STS);
    return d;
  endfunction

  function automatic logic [3:0] model_grp(input int kind);
    bit one, two_op, two_w;
    one    = (kind == K_NEG);
    two_op = (kind >= K_ADD && kind <= K_OR);
    two_w  = (kind == K_LDS || kind == K_STS);
    return {two_w, two_op, one, one | two_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int kind, input logic [4:0] rd,
                         input logic [4:0] rr, input logic [15:0] imm);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".type"},  32'(opcode_type), 32'(1) << kind);
    chk({tag, ".group"}, 32'(opcode_group), 32'(model_grp(kind)));
    chk({tag, ".rd"},    32'(opcode_rd), 32'(rd));
    chk({tag, ".rr"},    32'(opcode_rr), 32'(rr));
    chk({tag, ".imm"},   32'(opcode_imm), 32'(imm));
  endtask

  // One clock: apply inputs, compare against the model mid-cycle, advance the model.
  task automatic cycle(input logic iv, input logic [15:0] wd, input logic ordy, input logic fl);
    bit exp_rdy, acc, cons;
    dec_t d;
    in_valid = iv; in_word = wd; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_rdy = (!m_valid || ordy) && !fl;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("type", 32'(opcode_type), 32'(1) << m_out.kind);
      chk("group", 32'(opcode_group), 32'(model_grp(m_out.kind)));
      chk("rd", 32'(opcode_rd), 32'(m_out.rd));
      chk("rr", 32'(opcode_rr), 32'(m_out.rr));
      chk("imm", 32'(opcode_imm), 32'(m_out.imm));
    end
    acc  = iv && exp_rdy;
    cons = m_valid && ordy;
    if (fl) begin
      m_valid = 0; m_pend = 0;
    end else begin
      if (cons) m_valid = 0;
      if (acc) begin
        if (m_pend) begin
          m_out = m_held; m_out.imm = wd; m_valid = 1; m_pend = 0;
        end else begin
          d = model_dec(wd);
          if (d.two) begin m_held = d; m_pend = 1; end
          else begin m_out = d; m_valid = 1; end
        end
      end
    end
    $display("cyc iv=%0d word=%04h ordy=%0d flush=%0d acc=%0d cons=%0d", iv, wd, ordy, fl, acc, cons);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return 16'h0000;
      1:  return 16'h0C00 | (r & 16'h03FF);
      2:  return 16'h1C00 | (r & 16'h03FF);
      3:  return 16'h1800 | (r & 16'h03FF);
      4:  return 16'h2000 | (r & 16'h03FF);
      5:  return 16'h2800 | (r & 16'h03FF);
      6:  return 16'h2C00 | (r & 16'h03FF);
      7:  return 16'h9401 | (r & 16'h01F0);
      8:  return 16'hE000 | (r & 16'h0FFF);
      9:  return 16'h9000 | (r & 16'h01F0);
      10: return 16'h9200 | (r & 16'h01F0);
      default: return r;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.type", 32'(opcode_type), 32'(1) << K_NOP);
    chk("rst.group", 32'(opcode_group), 32'd0);
    chk("rst.fields", {opcode_rd, opcode_rr, opcode_imm}, 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    $display("reset checked");
    @(posedge clk); #1;

    // back-to-back one-word stream
    cycle(1, 16'h0C12, 1, 0);
    chk_out("add", K_ADD, 5'd1, 5'd2, 16'h0);
    chk("add.grp", 32'(opcode_group), 32'h5);
    cycle(1, 16'h9501, 1, 0);
    chk_out("neg", K_NEG, 5'd16, 5'd0, 16'h0);
    chk("neg.grp", 32'(opcode_group), 32'h3);
    cycle(1, 16'hE5A3, 1, 0);
    chk_out("ldi", K_LDI, 5'd26, 5'd0, 16'h0053);
    chk("ldi.grp", 32'(opcode_group), 32'h0);
    cycle(0, 16'h0000, 1, 0);

    // two-word instruction with idle gap
    cycle(1, 16'h9100, 1, 0);
`ifdef DECODE_TWO_WORD_EN
    chk("lds.no_first_out", 32'(out_valid), 32'd0);
`else
    chk_out("lds_off.w1", K_UNK, 5'd0, 5'd0, 16'h0);
`endif
    repeat (3) cycle(0, 16'h0000, 1, 0);
    cycle(1, 16'h0460, 1, 0);
`ifdef DECODE_TWO_WORD_EN
    chk_out("lds", K_LDS, 5'd16, 5'd0, 16'h0460);
    chk("lds.grp", 32'(opcode_group), 32'h8);
`else
    chk_out("lds_off.w2", K_UNK, 5'd0, 5'd0, 16'h0);
`endif
    cycle(0, 16'h0000, 1, 0);

    // backpressure: output held, input stalled, then accepted on release
    cycle(1, 16'h0C12, 1, 0);
    repeat (4) cycle(1, 16'h2C01, 0, 0);
    chk("bp.held_rd", 32'(opcode_rd), 32'd1);
    cycle(1, 16'h2C01, 1, 0);
    chk_out("bp.mov", K_MOV, 5'd0, 5'd1, 16'h0);
    cycle(0, 16'h0000, 1, 0);

    // flush between STS halves
    cycle(1, 16'h9300, 1, 0);
    cycle(1, 16'h1234, 1, 1);
    chk("flush.valid", 32'(out_valid), 32'd0);
    cycle(1, 16'h2C01, 1, 0);
    chk_out("flush.mov", K_MOV, 5'd0, 5'd1, 16'h0);
    cycle(0, 16'h0000, 1, 0);

    // unknown encoding
    cycle(1, 16'hFFFF, 1, 0);
    chk_out("unk", K_UNK, 5'd0, 5'd0, 16'h0);
    cycle(0, 16'h0000, 1, 0);

    // randomized stream with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_word(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
